// File: rtl/instr_fetch_issue_if.sv
// Fetch/issue bus: instruction memory port, issued instruction fields and PC feedback.
// The master side belongs to instr_fetch_issue; the slave side is the memory/control/datapath.
interface instr_fetch_issue_if;
    logic        stall;
    logic        pc_src;
    logic [31:0] result;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rd_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm24;
    logic [31:0] pc_plus8;
    logic [31:0] instr_count;

    modport master (
        input  stall, pc_src, result, imem_rd_data,
        output imem_addr, imem_rd_en, instr, instr_valid, cond, op, funct,
               rn, rd, rm, imm24, pc_plus8, instr_count
    );

    modport slave (
        output stall, pc_src, result, imem_rd_data,
        input  imem_addr, imem_rd_en, instr, instr_valid, cond, op, funct,
               rn, rd, rm, imm24, pc_plus8, instr_count
    );
endinterface

// File: rtl/instr_fetch_issue.sv
// Program counter, 3-cycle fetch/wait/issue sequencer and instruction field split.
// Define INSTR_FETCH_COUNT_EN to build the consumed-instruction counter.
module instr_fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    instr_fetch_issue_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        consume;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic        unused_result_lsbs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        consume    = 1'b0;
        case (state)
            FETCH: state_next = WAIT;
            WAIT:  state_next = ISSUE;
            ISSUE: begin
                if (!bus.stall) begin
                    consume    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Read data is captured only at the end of WAIT, so anything returned
    // for a read interrupted by reset never reaches the instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            if (state == WAIT) begin
                instr_q <= bus.imem_rd_data;
            end
            if (consume) begin
                pc <= bus.pc_src ? {bus.result[31:2], 2'b00} : pc + 32'd4;
            end
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'h0;
        end else if (consume) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = 32'h0;
`endif

    assign unused_result_lsbs = ^bus.result[1:0];

    assign bus.imem_addr   = pc;
    assign bus.imem_rd_en  = (state == FETCH) && !rst;
    assign bus.pc_plus8    = pc + 32'd8;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == ISSUE);
    assign bus.cond        = instr_q[31:28];
    assign bus.op          = instr_q[27:26];
    assign bus.funct       = instr_q[25:20];
    assign bus.rn          = instr_q[19:16];
    assign bus.rd          = instr_q[15:12];
    assign bus.rm          = instr_q[3:0];
    assign bus.imm24       = instr_q[23:0];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Randomized bench for instr_fetch_issue against a cycle-age reference model,
// with directed reset, branch, stall and PC-wrap sequences up front.
module tb_instr_fetch_issue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    int          m_age;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    instr_fetch_issue_if bus ();

    instr_fetch_issue #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'hE203_3000;
        if (a == 32'h4) return 32'hE152_0003;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous memory: data for an asserted read appears after the edge;
    // otherwise the bus carries junk so a mistimed capture is visible.
    always @(posedge clk) begin
        if (bus.imem_rd_en) begin
            bus.imem_rd_data <= memword(bus.imem_addr);
        end else begin
            bus.imem_rd_data <= $urandom;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expCount();
`ifdef INSTR_FETCH_COUNT_EN
        return m_count;
`else
        return 32'h0;
`endif
    endfunction

    task automatic resetModel();
        m_age   = 0;
        m_pc    = RESET_PC;
        m_instr = 32'h0;
        m_count = 32'h0;
    endtask

    // One clock edge: inputs held across the edge, model advanced by the spec's rules.
    task automatic applyStimulus(input logic st, input logic ps, input logic [31:0] res);
        bus.stall  = st;
        bus.pc_src = ps;
        bus.result = res;
        @(posedge clk);
        if (m_age == 0) begin
            m_age = 1;
        end else if (m_age == 1) begin
            m_age   = 2;
            m_instr = memword(m_pc);
        end else if (!st) begin
            m_pc    = ps ? {res[31:2], 2'b00} : m_pc + 32'd4;
            m_count = m_count + 32'd1;
            m_age   = 0;
        end
        #1;
    endtask

    task automatic doReset(input bit immediate_checks);
        rst = 1'b1;
        resetModel();
        #1;
        if (immediate_checks) begin
            checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
            checkOutput("rst_addr", bus.imem_addr, RESET_PC);
            checkOutput("rst_rden", {31'b0, bus.imem_rd_en}, 32'h0);
            checkOutput("rst_count", bus.instr_count, 32'h0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        checkOutput("imem_addr", bus.imem_addr, m_pc);
        checkOutput("pc_plus8", bus.pc_plus8, m_pc + 32'd8);
        checkOutput("imem_rd_en", {31'b0, bus.imem_rd_en}, {31'b0, (m_age == 0) && !rst});
        checkOutput("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_age == 2});
        checkOutput("instr", bus.instr, m_instr);
        checkOutput("cond", {28'b0, bus.cond}, {28'b0, m_instr[31:28]});
        checkOutput("op", {30'b0, bus.op}, {30'b0, m_instr[27:26]});
        checkOutput("funct", {26'b0, bus.funct}, {26'b0, m_instr[25:20]});
        checkOutput("rn", {28'b0, bus.rn}, {28'b0, m_instr[19:16]});
        checkOutput("rd", {28'b0, bus.rd}, {28'b0, m_instr[15:12]});
        checkOutput("rm", {28'b0, bus.rm}, {28'b0, m_instr[3:0]});
        checkOutput("imm24", {8'b0, bus.imm24}, {8'b0, m_instr[23:0]});
        checkOutput("instr_count", bus.instr_count, expCount());
    end

    initial begin
        vectors    = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.stall  = 1'b0;
        bus.pc_src = 1'b0;
        bus.result = 32'h0;
        resetModel();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;

        // First fetch and issue of mem[0] = AND R3,R3,#0
        checkOutput("c0_addr", bus.imem_addr, 32'h0);
        checkOutput("c0_rden", {31'b0, bus.imem_rd_en}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("c2_valid", {31'b0, bus.instr_valid}, 32'h1);
        checkOutput("c2_cond", {28'b0, bus.cond}, 32'hE);
        checkOutput("c2_op", {30'b0, bus.op}, 32'h0);
        checkOutput("c2_funct", {26'b0, bus.funct}, 32'h20);
        checkOutput("c2_rd", {28'b0, bus.rd}, 32'h3);
        checkOutput("c2_rn", {28'b0, bus.rn}, 32'h3);

        // Sequential fetch of mem[4] = CMP R2,R3
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("c3_addr", bus.imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("c5_funct", {26'b0, bus.funct}, 32'h15);
        checkOutput("c5_rn", {28'b0, bus.rn}, 32'h2);
        checkOutput("c5_rd", {28'b0, bus.rd}, 32'h0);
        checkOutput("c5_rm", {28'b0, bus.rm}, 32'h3);
        checkOutput("c5_pc8", bus.pc_plus8, 32'hC);

        // Branch with misaligned target: low bits dropped
        applyStimulus(1'b0, 1'b1, 32'h0000_0102);
        checkOutput("br_addr", bus.imem_addr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Five stalled ISSUE cycles with pc_src toggling
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i[0], $urandom);
            checkOutput("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
            checkOutput("stall_rden", {31'b0, bus.imem_rd_en}, 32'h0);
            checkOutput("stall_addr", bus.imem_addr, 32'h0000_0100);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("unstall_addr", bus.imem_addr, 32'h0000_0104);

        // Branch to the top word, then sequential wrap to zero
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        checkOutput("top_pc8", bus.pc_plus8, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr", bus.imem_addr, 32'h0);
`ifdef INSTR_FETCH_COUNT_EN
        checkOutput("count5", bus.instr_count, 32'd5);
`else
        checkOutput("count5", bus.instr_count, 32'd0);
`endif

        // Reset in the middle of WAIT, then refetch from RESET_PC
        applyStimulus(1'b0, 1'b0, 32'h0);
        doReset(1'b1);
        checkOutput("refetch_addr", bus.imem_addr, RESET_PC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("refetch_instr", bus.instr, 32'hE203_3000);

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) begin
                doReset(1'b1);
            end else begin
                applyStimulus($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom);
            end
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
